// File: rtl/mem_io_responder.sv
// Far-end bus responder: unified RAM, I/O window, TX FIFO, RX pass-through,
// free-running cycle counter with byte-wise snapshot, sticky stop/overflow.
//
// Ports
//   clk_in, rst_n_in : clock and asynchronous active-low reset
//   bus_a            : 32-bit CPU byte address, bits 17:0 decoded
//   bus_wdata        : 8-bit write data from the CPU
//   bus_wr           : 1 = write, 0 = read (every cycle is an access)
//   bus_rdata        : 8-bit read data, valid one cycle after the read
//   io_buffer_full   : TX FIFO near full; the CPU holds I/O writes
//   tx_data          : TX FIFO head byte to the UART
//   tx_valid         : TX FIFO is not empty
//   tx_ready         : the UART accepts the head byte this cycle
//   rx_data          : byte received by the UART
//   rx_valid         : rx_data holds a byte
//   rx_ready         : pops the RX byte (combinational, one cycle)
//   program_stop     : sticky; set by a write to 0x30004
//   tx_overflow      : sticky; a TX push was dropped
module mem_io_responder #(
  parameter int    ADDR_W      = 17,
  parameter int    TX_DEPTH    = 8,
  parameter int    FULL_MARGIN = 2,
  parameter string INIT_FILE   = ""
) (
  input  logic        clk_in,
  input  logic        rst_n_in,
  input  logic [31:0] bus_a,
  input  logic [7:0]  bus_wdata,
  input  logic        bus_wr,
  output logic [7:0]  bus_rdata,
  output logic        io_buffer_full,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic        program_stop,
  output logic        tx_overflow
);

  localparam int PW = $clog2(TX_DEPTH);
  localparam int CW = PW + 1;

  logic [7:0]    ram  [2**ADDR_W];
  logic [7:0]    fifo [TX_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [CW-1:0] next_count;
  logic [31:0]   cnt;
  logic [31:0]   snap;

  logic          io;
  logic [15:0]   off;
  logic          rd_rx;
  logic          rd_cnt;
  logic          wr_tx;
  logic          wr_stop;
  logic [7:0]    io_rdata;
  logic          push_req;
  logic [7:0]    push_data;
  logic          pop;
  logic          accept;
  logic          unused_bits;

  assign unused_bits = ^bus_a[31:18];

  assign io      = bus_a[17:16] == 2'b11;
  assign off     = bus_a[15:0];
  assign rd_rx   = io && !bus_wr && off == 16'h0000;
  assign rd_cnt  = io && !bus_wr && off == 16'h0004;
  assign wr_tx   = io && bus_wr && off == 16'h0000;
  assign wr_stop = io && bus_wr && off == 16'h0004;

  assign rx_ready = rd_rx && rx_valid;

  always_comb begin
    io_rdata = 8'h00;
    unique case (1'b1)
      off == 16'h0000: io_rdata = rx_valid ? rx_data : 8'h00;
      off == 16'h0004: io_rdata = cnt[7:0];
      off == 16'h0005: io_rdata = snap[15:8];
      off == 16'h0006: io_rdata = snap[23:16];
      off == 16'h0007: io_rdata = snap[31:24];
      default:         io_rdata = 8'h00;
    endcase
  end

  // A stop write queues a NUL so the UART side sees the end of output.
  assign push_req  = (wr_tx && bus_wdata != 8'h00) || wr_stop;
  assign push_data = wr_stop ? 8'h00 : bus_wdata;
  assign tx_valid  = count != '0;
  assign tx_data   = fifo[rd_ptr];
  assign pop       = tx_valid && tx_ready;
  assign accept    = push_req && (count < CW'(TX_DEPTH) || pop);

  assign next_count = count + CW'(accept) - CW'(pop);

  always_ff @(posedge clk_in) begin
    if (!io && bus_wr) ram[bus_a[ADDR_W-1:0]] <= bus_wdata;
  end

  always_ff @(posedge clk_in) begin
    if (accept) fifo[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      bus_rdata      <= 8'h00;
      io_buffer_full <= 1'b0;
      program_stop   <= 1'b0;
      tx_overflow    <= 1'b0;
      cnt            <= '0;
      snap           <= '0;
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      count          <= '0;
    end else begin
      cnt <= cnt + 32'd1;
      if (!bus_wr) bus_rdata <= io ? io_rdata : ram[bus_a[ADDR_W-1:0]];
      if (rd_cnt) snap <= cnt;
      if (wr_stop) program_stop <= 1'b1;
      if (push_req && !accept) tx_overflow <= 1'b1;
      if (accept) wr_ptr <= wr_ptr + PW'(1);
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      count          <= next_count;
      io_buffer_full <= next_count >= CW'(TX_DEPTH - FULL_MARGIN);
    end
  end

endmodule

// File: tb/tb_mem_io_responder.sv
// Directed testbench for mem_io_responder.
// Inputs change on negedges; outputs are read a half cycle after the posedge.
module tb_mem_io_responder;

  logic        clk_in = 1'b0;
  logic        rst_n_in = 1'b0;
  logic [31:0] bus_a = 32'h0003_FFFF;
  logic [7:0]  bus_wdata = 8'h00;
  logic        bus_wr = 1'b0;
  logic [7:0]  bus_rdata;
  logic        io_buffer_full;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic        rx_ready;
  logic        program_stop;
  logic        tx_overflow;

  localparam logic [31:0] IDLE = 32'h0003_FFFF;

  int nvec = 0;
  int nerr = 0;
  logic [7:0] q[$];

  mem_io_responder dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in),
    .bus_a(bus_a), .bus_wdata(bus_wdata), .bus_wr(bus_wr),
    .bus_rdata(bus_rdata), .io_buffer_full(io_buffer_full),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .program_stop(program_stop), .tx_overflow(tx_overflow)
  );

  always #5 clk_in = ~clk_in;

  // Record every byte the UART accepts, just before the popping edge.
  always @(negedge clk_in) begin
    #4;
    if (rst_n_in && tx_valid && tx_ready) q.push_back(tx_data);
  end

  task automatic cyc(input logic [31:0] a, input logic [7:0] d,
                     input logic w);
    bus_a = a; bus_wdata = d; bus_wr = w;
    @(negedge clk_in);
  endtask

  task automatic reset_dut();
    bus_a = IDLE; bus_wdata = 8'h00; bus_wr = 1'b0;
    tx_ready = 1'b0; rx_valid = 1'b0;
    rst_n_in = 1'b0;
    repeat (3) @(negedge clk_in);
    rst_n_in = 1'b1;
  endtask

  task automatic test_reset();
    reset_dut();
    nvec++; if (bus_rdata !== 8'h00) begin nerr++; $display("FAIL rst_rdata: got %h want 00", bus_rdata); end
    nvec++; if (tx_valid !== 1'b0) begin nerr++; $display("FAIL rst_tx_valid: got %b want 0", tx_valid); end
    nvec++; if (rx_ready !== 1'b0) begin nerr++; $display("FAIL rst_rx_ready: got %b want 0", rx_ready); end
    nvec++; if (io_buffer_full !== 1'b0) begin nerr++; $display("FAIL rst_full: got %b want 0", io_buffer_full); end
    nvec++; if (program_stop !== 1'b0) begin nerr++; $display("FAIL rst_stop: got %b want 0", program_stop); end
    nvec++; if (tx_overflow !== 1'b0) begin nerr++; $display("FAIL rst_ovf: got %b want 0", tx_overflow); end
  endtask

  task automatic test_ram();
    cyc(32'h0001_2340 >> 4, 8'hA5, 1'b1);
    cyc(32'h0000_1234, 8'h00, 1'b0);
    nvec++; if (bus_rdata !== 8'hA5) begin nerr++; $display("FAIL ram_rd: got %h want a5", bus_rdata); end
    cyc(32'h0001_FFFF, 8'h3C, 1'b1);
    nvec++; if (bus_rdata !== 8'hA5) begin nerr++; $display("FAIL ram_hold: got %h want a5", bus_rdata); end
    cyc(32'h0001_FFFF, 8'h00, 1'b0);
    nvec++; if (bus_rdata !== 8'h3C) begin nerr++; $display("FAIL ram_top: got %h want 3c", bus_rdata); end
    cyc(32'h0000_1235, 8'h77, 1'b1);
    cyc(32'hFFFC_1234, 8'h00, 1'b0);
    nvec++; if (bus_rdata !== 8'hA5) begin nerr++; $display("FAIL ram_alias: got %h want a5", bus_rdata); end
    cyc(32'h0000_1235, 8'h00, 1'b0);
    nvec++; if (bus_rdata !== 8'h77) begin nerr++; $display("FAIL ram_adj: got %h want 77", bus_rdata); end
    cyc(IDLE, 8'h00, 1'b0);
  endtask

  task automatic test_tx_stream();
    q.delete();
    tx_ready = 1'b1;
    cyc(32'h0003_0000, 8'h48, 1'b1);
    cyc(32'h0003_0000, 8'h69, 1'b1);
    cyc(32'h0003_0000, 8'h00, 1'b1);
    repeat (4) cyc(IDLE, 8'h00, 1'b0);
    tx_ready = 1'b0;
    nvec++; if (q.size() !== 2) begin nerr++; $display("FAIL tx_len: got %0d want 2", q.size()); end
    nvec++; if (q.size() < 1 || q[0] !== 8'h48) begin nerr++; $display("FAIL tx_b0: want 48 (len %0d)", q.size()); end
    nvec++; if (q.size() < 2 || q[1] !== 8'h69) begin nerr++; $display("FAIL tx_b1: want 69 (len %0d)", q.size()); end
    nvec++; if (tx_valid !== 1'b0) begin nerr++; $display("FAIL tx_empty: got %b want 0", tx_valid); end
  endtask

  task automatic test_fifo_full();
    q.delete();
    tx_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      cyc(32'h0003_0000, 8'h11 + 8'(i), 1'b1);
      if (i == 4) begin
        nvec++; if (io_buffer_full !== 1'b0) begin nerr++; $display("FAIL full_at5: got %b want 0", io_buffer_full); end
      end
    end
    nvec++; if (io_buffer_full !== 1'b1) begin nerr++; $display("FAIL full_at6: got %b want 1", io_buffer_full); end
    cyc(32'h0003_0000, 8'h17, 1'b1);
    cyc(32'h0003_0000, 8'h18, 1'b1);
    nvec++; if (tx_overflow !== 1'b0) begin nerr++; $display("FAIL ovf_at8: got %b want 0", tx_overflow); end
    cyc(32'h0003_0000, 8'hEE, 1'b1);
    nvec++; if (tx_overflow !== 1'b1) begin nerr++; $display("FAIL ovf_at9: got %b want 1", tx_overflow); end
    tx_ready = 1'b1;
    cyc(32'h0003_0000, 8'h19, 1'b1);
    nvec++; if (io_buffer_full !== 1'b1) begin nerr++; $display("FAIL full_pushpop: got %b want 1", io_buffer_full); end
    repeat (10) cyc(IDLE, 8'h00, 1'b0);
    tx_ready = 1'b0;
    nvec++; if (q.size() !== 9) begin nerr++; $display("FAIL drain_len: got %0d want 9", q.size()); end
    for (int i = 0; i < 9; i++) begin
      nvec++;
      if (q.size() <= i || q[i] !== 8'h11 + 8'(i)) begin
        nerr++; $display("FAIL drain_b%0d: want %h (len %0d)", i, 8'h11 + 8'(i), q.size());
      end
    end
    nvec++; if (io_buffer_full !== 1'b0) begin nerr++; $display("FAIL full_drained: got %b want 0", io_buffer_full); end
    nvec++; if (tx_overflow !== 1'b1) begin nerr++; $display("FAIL ovf_sticky: got %b want 1", tx_overflow); end
  endtask

  task automatic test_rx();
    rx_valid = 1'b1; rx_data = 8'h37;
    bus_a = 32'h0003_0000; bus_wr = 1'b0; bus_wdata = 8'h00;
    #1;
    nvec++; if (rx_ready !== 1'b1) begin nerr++; $display("FAIL rx_pulse: got %b want 1", rx_ready); end
    @(negedge clk_in);
    nvec++; if (bus_rdata !== 8'h37) begin nerr++; $display("FAIL rx_data: got %h want 37", bus_rdata); end
    bus_a = IDLE;
    #1;
    nvec++; if (rx_ready !== 1'b0) begin nerr++; $display("FAIL rx_pulse_end: got %b want 0", rx_ready); end
    @(negedge clk_in);
    bus_a = 32'h0003_0001;
    #1;
    nvec++; if (rx_ready !== 1'b0) begin nerr++; $display("FAIL rx_other_addr: got %b want 0", rx_ready); end
    @(negedge clk_in);
    nvec++; if (bus_rdata !== 8'h00) begin nerr++; $display("FAIL io_other_rd: got %h want 00", bus_rdata); end
    bus_a = 32'h0003_0000; bus_wr = 1'b1;
    #1;
    nvec++; if (rx_ready !== 1'b0) begin nerr++; $display("FAIL rx_on_write: got %b want 0", rx_ready); end
    @(negedge clk_in);
    rx_valid = 1'b0;
    cyc(32'h0000_1234, 8'h00, 1'b0);
    bus_a = 32'h0003_0000;
    #1;
    nvec++; if (rx_ready !== 1'b0) begin nerr++; $display("FAIL rx_idle: got %b want 0", rx_ready); end
    @(negedge clk_in);
    nvec++; if (bus_rdata !== 8'h00) begin nerr++; $display("FAIL rx_empty: got %h want 00", bus_rdata); end
    cyc(IDLE, 8'h00, 1'b0);
  endtask

  task automatic test_stop_io();
    tx_ready = 1'b0;
    cyc(32'h0003_0001, 8'h44, 1'b1);
    nvec++; if (tx_valid !== 1'b0) begin nerr++; $display("FAIL io_other_wr: got %b want 0", tx_valid); end
    cyc(32'h0003_0004, 8'h55, 1'b1);
    nvec++; if (program_stop !== 1'b1) begin nerr++; $display("FAIL stop_set: got %b want 1", program_stop); end
    nvec++; if (tx_valid !== 1'b1) begin nerr++; $display("FAIL stop_push: got %b want 1", tx_valid); end
    nvec++; if (tx_data !== 8'h00) begin nerr++; $display("FAIL stop_byte: got %h want 00", tx_data); end
    tx_ready = 1'b1;
    cyc(IDLE, 8'h00, 1'b0);
    tx_ready = 1'b0;
    cyc(IDLE, 8'h00, 1'b0);
    nvec++; if (program_stop !== 1'b1) begin nerr++; $display("FAIL stop_sticky: got %b want 1", program_stop); end
    nvec++; if (tx_valid !== 1'b0) begin nerr++; $display("FAIL stop_drained: got %b want 0", tx_valid); end
  endtask

  task automatic test_reset_mid();
    tx_ready = 1'b0;
    cyc(32'h0003_0004, 8'h00, 1'b1);
    cyc(32'h0003_0000, 8'h41, 1'b1);
    cyc(32'h0003_0000, 8'h42, 1'b1);
    bus_a = IDLE; bus_wr = 1'b0;
    nvec++; if (tx_valid !== 1'b1) begin nerr++; $display("FAIL mid_queued: got %b want 1", tx_valid); end
    #2 rst_n_in = 1'b0;
    #1;
    nvec++; if (tx_valid !== 1'b0) begin nerr++; $display("FAIL mid_async_txv: got %b want 0", tx_valid); end
    nvec++; if (program_stop !== 1'b0) begin nerr++; $display("FAIL mid_async_stop: got %b want 0", program_stop); end
    repeat (2) @(negedge clk_in);
    rst_n_in = 1'b1;
    repeat (2) cyc(IDLE, 8'h00, 1'b0);
    nvec++; if (tx_valid !== 1'b0) begin nerr++; $display("FAIL mid_txv: got %b want 0", tx_valid); end
    nvec++; if (program_stop !== 1'b0) begin nerr++; $display("FAIL mid_stop: got %b want 0", program_stop); end
    nvec++; if (tx_overflow !== 1'b0) begin nerr++; $display("FAIL mid_ovf: got %b want 0", tx_overflow); end
    q.delete();
    tx_ready = 1'b1;
    cyc(32'h0003_0000, 8'h5A, 1'b1);
    repeat (4) cyc(IDLE, 8'h00, 1'b0);
    tx_ready = 1'b0;
    nvec++; if (q.size() !== 1) begin nerr++; $display("FAIL mid_count: got len %0d want 1", q.size()); end
    nvec++; if (q.size() < 1 || q[0] !== 8'h5A) begin nerr++; $display("FAIL mid_byte: want 5a (len %0d)", q.size()); end
  endtask

  task automatic test_counter();
    reset_dut();
    repeat (511) @(negedge clk_in);
    cyc(32'h0003_0004, 8'h00, 1'b0);
    nvec++; if (bus_rdata !== 8'hFF) begin nerr++; $display("FAIL cnt_b0: got %h want ff", bus_rdata); end
    cyc(32'h0003_0005, 8'h00, 1'b0);
    nvec++; if (bus_rdata !== 8'h01) begin nerr++; $display("FAIL cnt_b1: got %h want 01", bus_rdata); end
    cyc(32'h0003_0006, 8'h00, 1'b0);
    nvec++; if (bus_rdata !== 8'h00) begin nerr++; $display("FAIL cnt_b2: got %h want 00", bus_rdata); end
    cyc(32'h0003_0007, 8'h00, 1'b0);
    nvec++; if (bus_rdata !== 8'h00) begin nerr++; $display("FAIL cnt_b3: got %h want 00", bus_rdata); end
    cyc(IDLE, 8'h00, 1'b0);
  endtask

  initial begin
    test_reset();
    test_ram();
    test_tx_stream();
    test_fifo_full();
    test_rx();
    test_stop_io();
    test_reset_mid();
    test_counter();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
